instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 217 +++++++++++++++++++++
 tb/tb_instr_encoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes instruction requests into 32-bit words and streams them to instruction memory

// Encoded-word queue: strict FIFO. The caller never pushes into a full queue
// unless it pops in the same cycle, and never pops an empty one.
module instr_encoder_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the queue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// Top: request handshake, encoder, queue and memory-side write sequencing.
module instr_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [3:0]                    req_op,
    input  logic [4:0]                    req_rs,
    input  logic [4:0]                    req_rt,
    input  logic [4:0]                    req_rd,
    input  logic [23:0]                   req_imm,
    input  logic                          out_en,
    output logic                          imem_we,
    output logic [ADDR_W-1:0]             imem_addr,
    output logic [31:0]                   imem_wdata,
    output logic                          err_illegal,
    output logic                          wrapped,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_NAND = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_MOVE = 4'd4;
    localparam logic [3:0] OP_JR   = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_BLT  = 4'd9;
    localparam logic [3:0] OP_SUBI = 4'd10;
    localparam logic [3:0] OP_ADDI = 4'd11;
    localparam logic [3:0] OP_BEQI = 4'd12;
    localparam logic [3:0] OP_J    = 4'd13;

    localparam logic [7:0] OPC_R    = 8'd51;
    localparam logic [7:0] OPC_LW   = 8'd52;
    localparam logic [7:0] OPC_SW   = 8'd53;
    localparam logic [7:0] OPC_BEQ  = 8'd54;
    localparam logic [7:0] OPC_BLT  = 8'd55;
    localparam logic [7:0] OPC_SUBI = 8'd56;
    localparam logic [7:0] OPC_ADDI = 8'd57;
    localparam logic [7:0] OPC_BEQI = 8'd58;
    localparam logic [7:0] OPC_J    = 8'd59;

    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_NAND = 6'd39;
    localparam logic [5:0] FN_SLL  = 6'd0;
    localparam logic [5:0] FN_MOVE = 6'd33;
    localparam logic [5:0] FN_JR   = 6'd8;

    logic [31:0]       enc_word;
    logic              op_legal;
    logic              accept;
    logic              push;
    logic              pop;
    logic [31:0]       fifo_head;
    logic [LVL_W-1:0]  fifo_level;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_illegal_q, err_illegal_d;
    logic              wrapped_q, wrapped_d;

    // Combinational encoder: field packing per mnemonic, unused bits forced to zero
    always_comb begin
        enc_word = '0;
        op_legal = 1'b1;
        unique case (req_op)
            OP_ADD:  enc_word = {OPC_R, req_rs, req_rt, req_rd, req_imm[2:0], FN_ADD};
            OP_OR:   enc_word = {OPC_R, req_rs, req_rt, req_rd, req_imm[2:0], FN_OR};
            OP_NAND: enc_word = {OPC_R, req_rs, req_rt, req_rd, req_imm[2:0], FN_NAND};
            OP_SLL:  enc_word = {OPC_R, req_rs, req_rt, req_rd, req_imm[2:0], FN_SLL};
            OP_MOVE: enc_word = {OPC_R, req_rs, req_rt, req_rd, req_imm[2:0], FN_MOVE};
            OP_JR:   enc_word = {OPC_R, req_rs, 5'd0, 5'd0, 3'd0, FN_JR};
            OP_LW:   enc_word = {OPC_LW,   req_rs, req_rt, req_imm[13:0]};
            OP_SW:   enc_word = {OPC_SW,   req_rs, req_rt, req_imm[13:0]};
            OP_BEQ:  enc_word = {OPC_BEQ,  req_rs, req_rt, req_imm[13:0]};
            OP_BLT:  enc_word = {OPC_BLT,  req_rs, req_rt, req_imm[13:0]};
            OP_SUBI: enc_word = {OPC_SUBI, req_rs, req_rt, req_imm[13:0]};
            OP_ADDI: enc_word = {OPC_ADDI, req_rs, req_rt, req_imm[13:0]};
            OP_BEQI: enc_word = {OPC_BEQI, req_rs, req_rt, req_imm[13:0]};
            OP_J:    enc_word = {OPC_J, req_imm};
            default: op_legal = 1'b0;
        endcase
    end

    // Handshake and strobes: a pop frees a slot in the same cycle, so a full queue
    // still accepts when the memory side is draining it
    always_comb begin
        pop       = out_en && (fifo_level != '0);
        req_ready = (fifo_level < LVL_W'(FIFO_DEPTH)) || pop;
        accept    = req_valid && req_ready;
        push      = accept && op_legal;
    end

    instr_encoder_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (enc_word),
        .rdata (fifo_head),
        .level (fifo_level)
    );

    // Address counter advances once per completed write; sticky status flags
    always_comb begin
        addr_d        = addr_q;
        wrapped_d     = wrapped_q;
        err_illegal_d = err_illegal_q;
        if (pop) begin
            addr_d = addr_q + ADDR_W'(1);
            if (&addr_q) begin
                wrapped_d = 1'b1;
            end
        end
        if (accept && !op_legal) begin
            err_illegal_d = 1'b1;
        end
    end

    // Address and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q        <= '0;
            wrapped_q     <= 1'b0;
            err_illegal_q <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            wrapped_q     <= wrapped_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    assign imem_we     = pop;
    assign imem_addr   = addr_q;
    assign imem_wdata  = fifo_head;
    assign err_illegal = err_illegal_q;
    assign wrapped     = wrapped_q;
    assign level       = fifo_level;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder with directed vectors
module tb_instr_encoder;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'd0;
    logic [4:0]  req_rs = 5'd0;
    logic [4:0]  req_rt = 5'd0;
    logic [4:0]  req_rd = 5'd0;
    logic [23:0] req_imm = 24'd0;
    logic        out_en = 1'b0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        err_illegal;
    logic        wrapped;
    logic [2:0]  level;

    instr_encoder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rs      (req_rs),
        .req_rt      (req_rt),
        .req_rd      (req_rd),
        .req_imm     (req_imm),
        .out_en      (out_en),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .err_illegal (err_illegal),
        .wrapped     (wrapped),
        .level       (level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_addr = 8'd0;
    int         checks = 0;
    int         errors = 0;
    bit         done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        exp_addr = 8'd0;
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_err", 32'(err_illegal), 32'd0);
        chk("rst_wrapped", 32'(wrapped), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Drives one request starting just after a rising edge; returns after the next edge
    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [23:0] imm,
                        input logic [31:0] exp_word, input bit exp_acc, input string name);
        bit acc;
        req_valid = 1'b1;
        req_op    = op;
        req_rs    = rs;
        req_rt    = rt;
        req_rd    = rd;
        req_imm   = imm;
        @(negedge clk);
        acc = req_ready;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_rs    = 5'h1f;
        req_rt    = 5'h1f;
        req_rd    = 5'h1f;
        req_imm   = 24'hFFFFFF;
        chk({name, "_accept"}, 32'(acc), 32'(exp_acc));
        if (acc && op < 4'd14) begin
            exp_q.push_back('{addr: exp_addr, data: exp_word});
            exp_addr = exp_addr + 8'd1;
        end
    endtask

    task automatic drain(input string name);
        idle(8);
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_level0"}, 32'(level), 32'd0);
        chk({name, "_we0"}, 32'(imem_we), 32'd0);
    endtask

    initial begin
        fork
            // Monitor: every write must match the oldest outstanding expectation
            begin
                exp_t e;
                while (!done) begin
                    @(negedge clk);
                    if (imem_we === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_write: addr 0x%0h wdata 0x%0h, expected no write",
                                     imem_addr, imem_wdata);
                        end else begin
                            e = exp_q.pop_front();
                            chk("write_addr", 32'(imem_addr), 32'(e.addr));
                            chk("write_data", imem_wdata, e.data);
                        end
                    end
                end
            end
            // Stimulus
            begin
                // Basic add, latency and every mnemonic
                do_reset();
                out_en = 1'b1;
                send(4'd0, 5'd1, 5'd2, 5'd3, 24'd0, 32'h3308_8620, 1'b1, "add");
                chk("latency_we", 32'(imem_we), 32'd1);
                chk("latency_addr", 32'(imem_addr), 32'd0);
                chk("latency_data", imem_wdata, 32'h3308_8620);
                send(4'd1, 5'd5, 5'd6, 5'd7, 24'd0, 32'h3329_8E25, 1'b1, "or");
                send(4'd2, 5'd31, 5'd31, 5'd31, 24'd0, 32'h33FF_FE27, 1'b1, "nand");
                send(4'd3, 5'd0, 5'd8, 5'd9, 24'hFFFFFD, 32'h3302_1340, 1'b1, "sll");
                send(4'd4, 5'd2, 5'd0, 5'd6, 24'd0, 32'h3310_0C21, 1'b1, "move");
                send(4'd5, 5'd3, 5'd4, 5'd5, 24'd7, 32'h3318_0008, 1'b1, "jr");
                send(4'd6, 5'd1, 5'd2, 5'd31, 24'h000101, 32'h3408_8101, 1'b1, "lw");
                send(4'd7, 5'd10, 5'd11, 5'd31, 24'hFFFFFF, 32'h3552_FFFF, 1'b1, "sw");
                send(4'd8, 5'd1, 5'd1, 5'd0, 24'h000010, 32'h3608_4010, 1'b1, "beq");
                send(4'd9, 5'd0, 5'd0, 5'd0, 24'h002000, 32'h3700_2000, 1'b1, "blt");
                send(4'd10, 5'd2, 5'd3, 5'd0, 24'd1, 32'h3810_C001, 1'b1, "subi");
                send(4'd11, 5'd31, 5'd0, 5'd0, 24'd0, 32'h39F8_0000, 1'b1, "addi");
                send(4'd12, 5'd4, 5'd0, 5'd0, 24'd7, 32'h3A20_0007, 1'b1, "beqi");
                send(4'd13, 5'd0, 5'd0, 5'd0, 24'h00ABCD, 32'h3B00_ABCD, 1'b1, "j");
                drain("mnemonics");

                // Backpressure: fill with out_en low, then drain
                do_reset();
                out_en = 1'b0;
                send(4'd6, 5'd1, 5'd2, 5'd0, 24'h000101, 32'h3408_8101, 1'b1, "fill1");
                send(4'd6, 5'd2, 5'd3, 5'd0, 24'h000102, 32'h3410_C102, 1'b1, "fill2");
                send(4'd6, 5'd3, 5'd4, 5'd0, 24'h000103, 32'h3419_0103, 1'b1, "fill3");
                send(4'd6, 5'd4, 5'd5, 5'd0, 24'h000104, 32'h3421_4104, 1'b1, "fill4");
                send(4'd6, 5'd5, 5'd6, 5'd0, 24'h000105, 32'h0, 1'b0, "fill5");
                chk("full_level", 32'(level), 32'd4);
                chk("full_ready", 32'(req_ready), 32'd0);
                idle(3);
                chk("hold_addr", 32'(imem_addr), 32'd0);
                chk("hold_level", 32'(level), 32'd4);
                out_en = 1'b1;
                drain("backpressure");

                // Illegal op followed by a jump
                do_reset();
                out_en = 1'b1;
                send(4'd15, 5'd1, 5'd1, 5'd1, 24'd1, 32'h0, 1'b1, "illegal");
                chk("illegal_err", 32'(err_illegal), 32'd1);
                chk("illegal_level", 32'(level), 32'd0);
                send(4'd13, 5'd0, 5'd0, 5'd0, 24'h00ABCD, 32'h3B00_ABCD, 1'b1, "j_after_ill");
                drain("illegal");
                chk("illegal_sticky", 32'(err_illegal), 32'd1);

                // Push into a full queue while it pops
                do_reset();
                out_en = 1'b0;
                send(4'd0, 5'd1, 5'd2, 5'd3, 24'd0, 32'h3308_8620, 1'b1, "pf1");
                send(4'd1, 5'd5, 5'd6, 5'd7, 24'd0, 32'h3329_8E25, 1'b1, "pf2");
                send(4'd2, 5'd31, 5'd31, 5'd31, 24'd0, 32'h33FF_FE27, 1'b1, "pf3");
                send(4'd3, 5'd0, 5'd8, 5'd9, 24'hFFFFFD, 32'h3302_1340, 1'b1, "pf4");
                out_en = 1'b1;
                send(4'd12, 5'd4, 5'd0, 5'd0, 24'd7, 32'h3A20_0007, 1'b1, "pf_beqi");
                chk("pushpop_level", 32'(level), 32'd4);
                drain("pushpop");

                // Address wrap over 257 writes
                do_reset();
                out_en = 1'b1;
                for (int i = 0; i < 255; i++) begin
                    send(4'd13, 5'd0, 5'd0, 5'd0, 24'(i), 32'h3B00_0000 | 32'(i), 1'b1, "stream");
                end
                idle(3);
                chk("wrap_pre", 32'(wrapped), 32'd0);
                chk("wrap_pre_addr", 32'(imem_addr), 32'd255);
                send(4'd13, 5'd0, 5'd0, 5'd0, 24'd255, 32'h3B00_00FF, 1'b1, "stream256");
                idle(3);
                chk("wrap_set", 32'(wrapped), 32'd1);
                chk("wrap_addr", 32'(imem_addr), 32'd0);
                send(4'd13, 5'd0, 5'd0, 5'd0, 24'd256, 32'h3B00_0100, 1'b1, "stream257");
                drain("wrap");
                chk("wrap_sticky", 32'(wrapped), 32'd1);

                // Reset mid-stream with three words buffered
                out_en = 1'b0;
                send(4'd0, 5'd1, 5'd2, 5'd3, 24'd0, 32'h3308_8620, 1'b1, "mid1");
                send(4'd1, 5'd5, 5'd6, 5'd7, 24'd0, 32'h3329_8E25, 1'b1, "mid2");
                send(4'd14, 5'd0, 5'd0, 5'd0, 24'd0, 32'h0, 1'b1, "mid_ill");
                send(4'd2, 5'd31, 5'd31, 5'd31, 24'd0, 32'h33FF_FE27, 1'b1, "mid3");
                chk("mid_level", 32'(level), 32'd3);
                chk("mid_err", 32'(err_illegal), 32'd1);
                out_en = 1'b1;
                do_reset();
                send(4'd13, 5'd0, 5'd0, 5'd0, 24'h000042, 32'h3B00_0042, 1'b1, "post_reset");
                drain("post_reset");

                done = 1'b1;
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
